// File: rtl/subpel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : subpel_pkg
//  Description : Shared constants, frac encoding and the HEVC 8-tap luma
//                coefficient table used by the sub-pel row filter.
//  Contents    : NUM_PIXEL/PIX_W/OUT_W/PIPE sizing, derived bus widths,
//                frac_e encoding, c_coef table and coef_of() lookup.
//  Revision    : 1.0  initial release
// ============================================================================
package subpel_pkg;

    localparam int NUM_PIXEL = 8;                           // samples per row, rows per block
    localparam int ROWS      = NUM_PIXEL;
    localparam int PIX_W     = 8;                           // unsigned input pixel width
    localparam int OUT_W     = 16;                          // signed output sample width
    localparam int PIPE      = 3;                           // filter latency in cycles
    localparam int TAPS      = 8;
    localparam int TAG_W     = 8;
    localparam int COEF_W    = 8;
    localparam int ROW_IN_W  = (NUM_PIXEL + TAPS - 1) * PIX_W;  // 120
    localparam int ROW_OUT_W = NUM_PIXEL * OUT_W;               // 128

    typedef enum logic [1:0] {
        FRAC_INT = 2'd0,    // integer position, pass-through scaled by 64
        FRAC_A   = 2'd1,    // quarter sample
        FRAC_B   = 2'd2,    // half sample
        FRAC_C   = 2'd3     // three-quarter sample
    } frac_e;

    // Row 0 = FRAC_A, row 1 = FRAC_B, row 2 = FRAC_C; tap k multiplies pixel[i+k].
    localparam logic signed [COEF_W-1:0] c_coef [3][TAPS] = '{
        '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5,  8'sd1,  8'sd0},
        '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1},
        '{ 8'sd0, 8'sd1, -8'sd5,  8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1}
    };

    // The integer position is expressed as a single tap of 64 on pixel[i+3],
    // which is the same as pixel << 6 and lets every frac share one datapath.
    function automatic logic signed [COEF_W-1:0] coef_of(input logic [1:0] frac,
                                                          input logic [2:0] tap);
        logic signed [COEF_W-1:0] c;
        c = '0;
        case (frac_e'(frac))
            FRAC_A:  c = c_coef[0][tap];
            FRAC_B:  c = c_coef[1][tap];
            FRAC_C:  c = c_coef[2][tap];
            default: c = (tap == 3'd3) ? 8'sd64 : 8'sd0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/subpel_fir8.sv
`default_nettype none
// ============================================================================
//  Module      : subpel_fir8
//  Description : One output sample of the 8-tap luma filter, three register
//                stages: products, pairwise sums, final sum.
//  Ports       : clock    - rising-edge clock
//                reset    - asynchronous active-low reset
//                stage_en - per-stage load enables (bit s loads stage s+1)
//                pix      - 8 unsigned pixels, tap k at pix[8k+7:8k]
//                frac     - filter select for the pixels on pix this cycle
//                sample   - signed filtered sample, holds between loads
//  Revision    : 1.0  initial release
// ============================================================================
module subpel_fir8
    import subpel_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic [PIPE-1:0]           stage_en,
    input  logic [TAPS*PIX_W-1:0]     pix,
    input  logic [1:0]                frac,
    output logic signed [OUT_W-1:0]   sample
);

    logic signed [OUT_W-1:0] w_prod [TAPS];
    logic signed [OUT_W-1:0] r_prod [TAPS];
    logic signed [OUT_W-1:0] r_pair [TAPS/2];
    logic signed [OUT_W-1:0] r_sum;

    // Every product and partial sum lies well inside 16-bit signed range for
    // 8-bit pixels, so all arithmetic is carried at OUT_W without growth.
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        logic signed [OUT_W-1:0] w_coef_ext;
        logic signed [OUT_W-1:0] w_pix_ext;
        assign w_coef_ext = OUT_W'(coef_of(frac, 3'(k)));
        assign w_pix_ext  = {{(OUT_W-PIX_W){1'b0}}, pix[k*PIX_W +: PIX_W]};
        assign w_prod[k]  = w_coef_ext * w_pix_ext;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_prod[k] <= '0;
            end
            for (int j = 0; j < TAPS/2; j++) begin
                r_pair[j] <= '0;
            end
            r_sum <= '0;
        end else begin
            if (stage_en[0]) begin
                for (int k = 0; k < TAPS; k++) begin
                    r_prod[k] <= w_prod[k];
                end
            end
            if (stage_en[1]) begin
                for (int j = 0; j < TAPS/2; j++) begin
                    r_pair[j] <= r_prod[2*j] + r_prod[2*j+1];
                end
            end
            if (stage_en[2]) begin
                r_sum <= (r_pair[0] + r_pair[1]) + (r_pair[2] + r_pair[3]);
            end
        end
    end

    assign sample = r_sum;

endmodule
`default_nettype wire

// File: rtl/subpel_row_filter.sv
`default_nettype none
// ============================================================================
//  Module      : subpel_row_filter
//  Description : Filters 15-pixel rows with the frac-selected 8-tap luma
//                filter and assembles ROWS filtered rows into one block that
//                is handed downstream with a valid/ack handshake.
//  Ports       : clock, reset (async active-low)
//                in_valid/in_ready/in_row/in_tag/frac - input row handshake
//                row_valid/row_data/row_tag            - per-row result strobe
//                blk_valid/blk_data/blk_frac/blk_ack   - block handshake
//  Revision    : 1.0  initial release
// ============================================================================
module subpel_row_filter
    import subpel_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROW_IN_W-1:0]        in_row,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [1:0]                 frac,
    output logic                       row_valid,
    output logic [ROW_OUT_W-1:0]       row_data,
    output logic [TAG_W-1:0]           row_tag,
    output logic                       blk_valid,
    output logic [ROWS*ROW_OUT_W-1:0]  blk_data,
    output logic [1:0]                 blk_frac,
    input  logic                       blk_ack
);

    localparam int                 c_cnt_w = $clog2(ROWS + 1);
    localparam int                 c_idx_w = $clog2(ROWS);
    localparam logic [c_cnt_w-1:0] c_rows  = c_cnt_w'(ROWS);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(ROWS - 1);

    logic                   r_ready_en;
    logic [c_cnt_w-1:0]     r_acc_cnt;
    logic [c_cnt_w-1:0]     r_wr_cnt;
    logic [1:0]             r_frac;
    logic [PIPE-1:0]        r_vld;
    logic [TAG_W-1:0]       r_tag [PIPE];
    logic                   r_blk_valid;
    logic [ROW_OUT_W-1:0]   r_blk [ROWS];

    logic                   w_accept;
    logic                   w_ack;
    logic [1:0]             w_frac_eff;
    logic [PIPE-1:0]        w_stage_en;

    // r_ready_en keeps in_ready low while reset is held and for the edge on
    // which it is released, so the first acceptance is one cycle later.
    assign in_ready  = r_ready_en && (r_acc_cnt < c_rows);
    assign w_accept  = in_valid && in_ready;
    assign w_ack     = r_blk_valid && blk_ack;

    // The first row of a block uses frac straight from the port; later rows
    // use the value latched with that first row.
    assign w_frac_eff = (r_acc_cnt == '0) ? frac : r_frac;

    // Stage s of the filter loads when the row one stage upstream is valid.
    assign w_stage_en = {r_vld[PIPE-2:0], w_accept};

    assign row_valid = r_vld[PIPE-1];
    assign row_tag   = r_tag[PIPE-1];
    assign blk_valid = r_blk_valid;
    assign blk_frac  = r_frac;

    for (genvar i = 0; i < NUM_PIXEL; i++) begin : g_fir
        subpel_fir8 u_fir (
            .clock    (clock),
            .reset    (reset),
            .stage_en (w_stage_en),
            .pix      (in_row[i*PIX_W +: TAPS*PIX_W]),
            .frac     (w_frac_eff),
            .sample   (row_data[i*OUT_W +: OUT_W])
        );
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_blk
        assign blk_data[r*ROW_OUT_W +: ROW_OUT_W] = r_blk[r];
    end

    // Counters, frac latch, valid/tag pipeline and block-valid flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ready_en  <= 1'b0;
            r_acc_cnt   <= '0;
            r_wr_cnt    <= '0;
            r_frac      <= FRAC_INT;
            r_vld       <= '0;
            r_blk_valid <= 1'b0;
            for (int s = 0; s < PIPE; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_ready_en <= 1'b1;
            r_vld      <= {r_vld[PIPE-2:0], w_accept};

            if (w_accept) begin
                r_tag[0] <= in_tag;
            end
            for (int s = 1; s < PIPE; s++) begin
                if (r_vld[s-1]) begin
                    r_tag[s] <= r_tag[s-1];
                end
            end

            if (w_accept && (r_acc_cnt == '0)) begin
                r_frac <= frac;
            end

            // in_ready is low while a block is outstanding, so the ack can
            // never coincide with an accept or a row strobe.
            if (w_ack) begin
                r_acc_cnt   <= '0;
                r_wr_cnt    <= '0;
                r_blk_valid <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_acc_cnt <= r_acc_cnt + 1'b1;
                end
                if (row_valid) begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                    if (r_wr_cnt == c_last) begin
                        r_blk_valid <= 1'b1;
                    end
                end
            end
        end
    end

    // Block buffer: each strobed row lands in the next slot. A held block is
    // never overwritten because no row can be accepted until it is acked.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ROWS; r++) begin
                r_blk[r] <= '0;
            end
        end else if (row_valid && !r_blk_valid) begin
            r_blk[r_wr_cnt[c_idx_w-1:0]] <= row_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_subpel_row_filter.sv
`timescale 1ns/1ps
module tb_subpel_row_filter;

    logic           clock;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [119:0]   in_row;
    logic [7:0]     in_tag;
    logic [1:0]     frac;
    logic           row_valid;
    logic [127:0]   row_data;
    logic [7:0]     row_tag;
    logic           blk_valid;
    logic [1023:0]  blk_data;
    logic [1:0]     blk_frac;
    logic           blk_ack;

    int checks   = 0;
    int failures = 0;
    int rv_total = 0;

    subpel_row_filter dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .in_tag    (in_tag),
        .frac      (frac),
        .row_valid (row_valid),
        .row_data  (row_data),
        .row_tag   (row_tag),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_frac  (blk_frac),
        .blk_ack   (blk_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset && row_valid) rv_total++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference filter: straight convolution with the coefficient lists.
    function automatic logic [127:0] model_row(input logic [119:0] row, input logic [1:0] f);
        int c [8];
        int s;
        logic [127:0] r;
        case (f)
            2'd0:    c = '{0, 0, 0, 64, 0, 0, 0, 0};
            2'd1:    c = '{-1, 4, -10, 58, 17, -5, 1, 0};
            2'd2:    c = '{-1, 4, -11, 40, 40, -11, 4, -1};
            default: c = '{0, 1, -5, 17, 58, -10, 4, -1};
        endcase
        r = '0;
        for (int i = 0; i < 8; i++) begin
            s = 0;
            for (int k = 0; k < 8; k++) s += c[k] * int'(row[8*(i+k) +: 8]);
            r[16*i +: 16] = s[15:0];
        end
        return r;
    endfunction

    function automatic logic [119:0] pat_row(input int seed);
        logic [119:0] r;
        r = '0;
        for (int j = 0; j < 15; j++) r[8*j +: 8] = 8'((seed * 37 + j * 11 + 5) % 256);
        return r;
    endfunction

    task automatic send_row(input logic [119:0] row, input logic [7:0] tag, input logic [1:0] f);
        int n;
        in_valid = 1'b1;
        in_row   = row;
        in_tag   = tag;
        frac     = f;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_bit("send_row_ready", in_ready, 1'b1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        blk_ack  = 1'b0;
        reset    = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic wait_blk(output int n);
        n = 0;
        while (!blk_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_bit("blk_valid_arrives", blk_valid, 1'b1);
    endtask

    logic [119:0]  flat_row, imp_row, worst_row;
    logic [1023:0] snap;
    logic          stable;
    int            n;
    int            rv0;

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_row = '0; in_tag = '0; frac = '0; blk_ack = 1'b0;
        flat_row  = {15{8'd100}};
        imp_row   = '0;
        imp_row[31:24] = 8'hFF;
        worst_row = '0;
        worst_row[7:0] = 8'hFF; worst_row[23:16] = 8'hFF;
        worst_row[47:40] = 8'hFF; worst_row[63:56] = 8'hFF;

        // Reset state
        repeat (3) @(negedge clock);
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_row_valid", row_valid, 1'b0);
        check_vec("rst_row_data", row_data, 128'd0);
        check_vec("rst_row_tag", 128'(row_tag), 128'd0);
        check_bit("rst_blk_valid", blk_valid, 1'b0);
        check_bit("rst_blk_data_nonzero", |blk_data, 1'b0);
        check_vec("rst_blk_frac", 128'(blk_frac), 128'd0);
        reset = 1'b1;
        @(negedge clock);
        check_bit("ready_after_release", in_ready, 1'b1);

        // Flat field, frac=2: latency exactly 3 cycles, all samples 6400
        send_row(flat_row, 8'h11, 2'd2);
        check_bit("flat_lat_c1", row_valid, 1'b0);
        @(negedge clock);
        check_bit("flat_lat_c2", row_valid, 1'b0);
        @(negedge clock);
        check_bit("flat_lat_c3", row_valid, 1'b1);
        check_vec("flat_data", row_data, {8{16'd6400}});
        check_vec("flat_tag", 128'(row_tag), 128'h11);
        @(negedge clock);
        check_bit("flat_strobe_1cyc", row_valid, 1'b0);
        check_vec("flat_hold", row_data, {8{16'd6400}});

        // Worst negative as row 1: frac=0 on this row is ignored, block stays frac=2
        send_row(worst_row, 8'h22, 2'd0);
        repeat (2) @(negedge clock);
        check_bit("worst_valid", row_valid, 1'b1);
        check_vec("worst_sample0", 128'(row_data[15:0]), 128'(16'hE818));
        check_vec("worst_row", row_data, model_row(worst_row, 2'd2));
        check_vec("worst_tag", 128'(row_tag), 128'h22);

        // Impulse, frac=1
        do_reset();
        send_row(imp_row, 8'h33, 2'd1);
        repeat (2) @(negedge clock);
        check_bit("imp_valid", row_valid, 1'b1);
        check_vec("imp_data", row_data,
                  {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFF01, 16'h03FC, 16'hF60A, 16'h39C6});

        // Integer position, pixel3=255 -> 255<<6
        do_reset();
        send_row(imp_row, 8'h44, 2'd0);
        repeat (2) @(negedge clock);
        check_vec("int_data", row_data, {112'd0, 16'd16320});

        // Block fill: frac=3 on row 0, frac=1 on later rows; stray ack mid-fill
        do_reset();
        for (int r = 0; r < 4; r++) send_row(pat_row(r), 8'(8'h50 + r), (r == 0) ? 2'd3 : 2'd1);
        blk_ack = 1'b1;
        @(negedge clock);
        blk_ack = 1'b0;
        check_bit("stray_ack_blk_valid", blk_valid, 1'b0);
        for (int r = 4; r < 8; r++) send_row(pat_row(r), 8'(8'h50 + r), 2'd1);
        check_bit("full_in_ready_low", in_ready, 1'b0);

        // Ninth row held by upstream while the block is outstanding
        in_valid = 1'b1; in_row = pat_row(8); in_tag = 8'h58; frac = 2'd2;
        wait_blk(n);
        check_bit("blk_latency_3_to_4", (n >= 3 && n <= 4), 1'b1);
        check_vec("blk_frac_a", 128'(blk_frac), 128'd3);
        for (int r = 0; r < 8; r++)
            check_vec($sformatf("blkA_row%0d", r), blk_data[128*r +: 128], model_row(pat_row(r), 2'd3));

        snap   = blk_data;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            stable &= (blk_data === snap) && !in_ready && blk_valid && !row_valid;
        end
        check_bit("hold_stable_no_accept", stable, 1'b1);

        blk_ack = 1'b1;
        @(negedge clock);
        blk_ack = 1'b0;
        check_bit("ack_blk_valid_drop", blk_valid, 1'b0);
        check_bit("ack_in_ready_rise", in_ready, 1'b1);

        // The held row is accepted now as row 0 of the next block
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check_bit("row8_valid", row_valid, 1'b1);
        check_vec("row8_data", row_data, model_row(pat_row(8), 2'd2));
        check_vec("row8_tag", 128'(row_tag), 128'h58);
        for (int r = 9; r < 16; r++) send_row(pat_row(r), 8'(8'h50 + r), 2'd0);
        wait_blk(n);
        check_vec("blk_frac_b", 128'(blk_frac), 128'd2);
        check_vec("blkB_slot0", blk_data[127:0], model_row(pat_row(8), 2'd2));
        check_vec("blkB_slot7", blk_data[1023:896], model_row(pat_row(15), 2'd2));
        blk_ack = 1'b1;
        @(negedge clock);
        blk_ack = 1'b0;

        // Reset mid-block with rows in flight
        for (int r = 20; r < 25; r++) send_row(pat_row(r), 8'(r), 2'd1);
        reset = 1'b0;
        #1;
        check_bit("midrst_row_valid", row_valid, 1'b0);
        check_vec("midrst_row_data", row_data, 128'd0);
        check_bit("midrst_in_ready", in_ready, 1'b0);
        check_bit("midrst_blk_valid", blk_valid, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        rv0 = rv_total;
        for (int r = 30; r < 38; r++) send_row(pat_row(r), 8'(r), (r == 30) ? 2'd2 : 2'd3);
        wait_blk(n);
        check_vec("blkC_frac", 128'(blk_frac), 128'd2);
        for (int r = 0; r < 8; r++)
            check_vec($sformatf("blkC_row%0d", r), blk_data[128*r +: 128], model_row(pat_row(30 + r), 2'd2));
        check_vec("blkC_row_count", 128'(rv_total - rv0), 128'd8);
        blk_ack = 1'b1;
        @(negedge clock);
        blk_ack = 1'b0;
        check_bit("final_ready", in_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
